tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Receive end of the team's time-division multiplexed sample link. The transmit-side mux serialises CHANNELS samples per frame onto one bus, with a sync flag on channel 0.
- This block locks to the frame sync and steers each sample to its channel slot in a staging buffer. On frame completion it publishes all channels together.
- Sits between the serial link and the per-channel consumers. Consumers only ever see complete, coherent frames.

Parameters:
- WIDTH, 8, bits per sample.
- CHANNELS, 4, samples per frame (≥2). Channel counter width = clog2(CHANNELS).
- CNT_W, 16, width of the frame counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- din_valid  input  1  din/din_sync qualify this cycle.
- din_sync  input  1  marks the channel-0 sample of a frame; ignored when din_valid=0.
- din  input  WIDTH  sample.
- frame_data  output  CHANNELS*WIDTH  last complete frame; channel i at bits [i*WIDTH +: WIDTH].
- frame_valid  output  1  one-cycle pulse when frame_data updates.
- locked  output  1  high while in LOCKED state.
- sync_err  output  1  one-cycle pulse on framing violation.
- frame_cnt  output  CNT_W  completed frames since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at clk edge):
  - All outputs and internal registers clear to 0.
  - State = HUNT, channel counter = 0.
  - Reset mid-frame discards the partial frame; frame_data is cleared.
- Accepted sample: din_valid=1 at a clock edge. Cycles with din_valid=0 change nothing; the counter holds and gaps of any length are allowed.
- State HUNT:
  - Accepted sample with din_sync=0: dropped, no error.
  - Accepted sample with din_sync=1: stored in staging slot 0, counter←1, state←LOCKED.
- State LOCKED, per accepted sample:
  - din_sync=0 and counter≠0: store in staging slot[counter], then advance counter.
  - din_sync=1 and counter=0: normal frame start. Store in slot 0, counter←1.
  - din_sync=1 and counter≠0 (early sync): sync_err pulses and the partial frame is discarded. The sample is stored in slot 0, counter←1, and state stays LOCKED.
  - din_sync=0 and counter=0 (missing sync): sync_err pulses, the sample is dropped, and state←HUNT.
- Frame completion: the sample accepted with counter=CHANNELS-1 completes the frame.
  - Counter wraps to 0.
  - On the same edge, frame_data ← {din, staging slots CHANNELS-2..0}.
  - frame_valid=1 for exactly the following cycle.
  - frame_cnt increments on the same edge.
- Latency: one cycle from the edge accepting the last sample to frame_valid/frame_data visible. Back-to-back frames give frame_valid every CHANNELS cycles.
- frame_data changes only on frame completion or reset. Aborted frames never reach it; the previous frame is retained.
- locked is registered: it rises the cycle after the accepted sync sample in HUNT, and falls the cycle after a missing-sync error.
- sync_err and frame_valid are registered single-cycle pulses. They are never asserted on the same cycle, because error cases never complete a frame.
- din_sync with din_valid=0 is ignored in every state.
- Staging buffer contents are don't-care between frames and are not observable.

Test Plan (WIDTH=8, CHANNELS=4):
- Reset: hold rst 2 cycles with random din/din_valid → frame_data=0, frame_valid=0, locked=0, sync_err=0, frame_cnt=0.
- Normal frame: A0(sync), A1, B2, C3 on consecutive cycles → cycle after C3: frame_data=0xC3B2A1A0, frame_valid 1 cycle, frame_cnt=1. locked=1 from the cycle after A0.
- Hunt and gaps: 0x11, 0x22 without sync, then 0x10(sync), 0x20, 0x30, 0x40 with 3 idle cycles between each → 0x11/0x22 dropped, no sync_err, frame_data=0x40302010, frame_cnt=1.
- Early sync: after a good frame 0x04030201, send 0xAA(sync), 0xBB, 0xCC(sync), 0xDD, 0xEE, 0xFF → sync_err pulses once, cycle after 0xCC. Next frame_data=0xFFEEDDCC; 0x04030201 held until then.
- Missing sync: complete a frame, then send 0x55 without sync → sync_err 1 cycle, locked falls, frame_valid stays 0. A later sync frame relocks.
- Reset mid-frame: 0x01(sync), 0x02, assert rst, then 0x03, 0x04 without sync → no frame_valid, locked=0, frame_data=0.

Source files
------------

// File: rtl/tdm_demux.sv
// Receive side of the TDM sample link. Locks to the channel-0 sync flag and
// steers each accepted sample into a staging slot. Once the last channel of a
// frame arrives, all channels are published together as one coherent frame.
module tdm_demux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din_valid,
    input  logic                      din_sync,
    input  logic [WIDTH-1:0]          din,
    output logic [CHANNELS*WIDTH-1:0] frame_data,
    output logic                      frame_valid,
    output logic                      locked,
    output logic                      sync_err,
    output logic [CNT_W-1:0]          frame_cnt
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                    state_reg, state_next;
    logic [CH_W-1:0]           ch_reg, ch_next;
    logic                      store_en;
    logic [CH_W-1:0]           store_idx;
    logic                      complete;
    logic                      err;

    logic [CHANNELS*WIDTH-1:0] frame_data_reg;
    logic [CHANNELS*WIDTH-1:0] frame_next;
    logic                      frame_valid_reg;
    logic                      locked_reg;
    logic                      sync_err_reg;
    logic [CNT_W-1:0]          frame_cnt_reg;

    // Framing decisions for the sample presented this cycle.
    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        store_en   = 1'b0;
        store_idx  = ch_reg;
        complete   = 1'b0;
        err        = 1'b0;
        if (din_valid) begin
            if (state_reg == ST_HUNT) begin
                // Unsynced samples are silently dropped while hunting.
                if (din_sync) begin
                    store_en   = 1'b1;
                    store_idx  = '0;
                    ch_next    = CH_W'(1);
                    state_next = ST_LOCKED;
                end
            end else if (din_sync) begin
                // Sync always restarts the frame; mid-frame it is an error and
                // the partial frame is abandoned.
                store_en  = 1'b1;
                store_idx = '0;
                ch_next   = CH_W'(1);
                err       = (ch_reg != '0);
            end else if (ch_reg != '0) begin
                store_en  = 1'b1;
                store_idx = ch_reg;
                if (ch_reg == LAST_CH) begin
                    complete = 1'b1;
                    ch_next  = '0;
                end else begin
                    ch_next = ch_reg + CH_W'(1);
                end
            end else begin
                // Expected a sync at channel 0 and did not get one.
                err        = 1'b1;
                state_next = ST_HUNT;
            end
        end
    end

    // Staging slots for channels 0..CHANNELS-2; the last channel is taken
    // straight from din on the completing edge, so it needs no slot.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS - 1; gi++) begin : g_stage
            logic [WIDTH-1:0] slot_reg;

            // Capture din when this slot is the target of an accepted sample.
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (store_en && (store_idx == CH_W'(gi))) begin
                    slot_reg <= din;
                end
            end

            assign frame_next[gi*WIDTH +: WIDTH] = slot_reg;
        end
    endgenerate

    assign frame_next[(CHANNELS-1)*WIDTH +: WIDTH] = din;

    // Framing state, channel counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_HUNT;
            ch_reg          <= '0;
            frame_data_reg  <= '0;
            frame_valid_reg <= 1'b0;
            locked_reg      <= 1'b0;
            sync_err_reg    <= 1'b0;
            frame_cnt_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            ch_reg          <= ch_next;
            frame_valid_reg <= complete;
            sync_err_reg    <= err;
            locked_reg      <= (state_next == ST_LOCKED);
            if (complete) begin
                frame_data_reg <= frame_next;
                frame_cnt_reg  <= frame_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign frame_data  = frame_data_reg;
    assign frame_valid = frame_valid_reg;
    assign locked      = locked_reg;
    assign sync_err    = sync_err_reg;
    assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (WIDTH=8, CHANNELS=4): reset, normal frame,
// hunting with gaps, early sync, missing sync and reset mid-frame.
module tb_tdm_demux;

    logic        clk;
    logic        rst;
    logic        din_valid;
    logic        din_sync;
    logic [7:0]  din;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        locked;
    logic        sync_err;
    logic [15:0] frame_cnt;

    int n_cmp;
    int n_err;

    tdm_demux #(.WIDTH(8), .CHANNELS(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din_sync    (din_sync),
        .din         (din),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts, prints one line per comparison.
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Present one cycle of input, then step to just after the clock edge.
    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        din_valid = v;
        din_sync  = s;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with a stray sync flag and random data, which must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 8'($urandom));
            check_val("idle_fv", 64'(frame_valid), 64'd0);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) drive(1'($urandom), 1'($urandom), 8'($urandom));
        rst = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        din_valid = 1'b0;
        din_sync  = 1'b0;
        din       = 8'h00;

        // Reset with random inputs.
        do_reset(2);
        check_val("rst_fd",   64'(frame_data),  64'd0);
        check_val("rst_fv",   64'(frame_valid), 64'd0);
        check_val("rst_lock", 64'(locked),      64'd0);
        check_val("rst_err",  64'(sync_err),    64'd0);
        check_val("rst_cnt",  64'(frame_cnt),   64'd0);

        // Normal frame A0 A1 B2 C3.
        drive(1'b1, 1'b1, 8'hA0);
        check_val("nf_lock", 64'(locked), 64'd1);
        check_val("nf_fv0",  64'(frame_valid), 64'd0);
        drive(1'b1, 1'b0, 8'hA1);
        drive(1'b1, 1'b0, 8'hB2);
        check_val("nf_fv2",  64'(frame_valid), 64'd0);
        drive(1'b1, 1'b0, 8'hC3);
        check_val("nf_fd",   64'(frame_data),  64'hC3B2A1A0);
        check_val("nf_fv",   64'(frame_valid), 64'd1);
        check_val("nf_cnt",  64'(frame_cnt),   64'd1);
        idle(1);

        // Hunt and gaps.
        do_reset(1);
        drive(1'b1, 1'b0, 8'h11);
        check_val("hg_err11",  64'(sync_err), 64'd0);
        check_val("hg_lock11", 64'(locked),   64'd0);
        drive(1'b1, 1'b0, 8'h22);
        check_val("hg_err22",  64'(sync_err), 64'd0);
        check_val("hg_lock22", 64'(locked),   64'd0);
        drive(1'b1, 1'b1, 8'h10);
        check_val("hg_lock10", 64'(locked),   64'd1);
        idle(3);
        drive(1'b1, 1'b0, 8'h20);
        idle(3);
        drive(1'b1, 1'b0, 8'h30);
        idle(3);
        drive(1'b1, 1'b0, 8'h40);
        check_val("hg_fd",  64'(frame_data),  64'h40302010);
        check_val("hg_fv",  64'(frame_valid), 64'd1);
        check_val("hg_cnt", 64'(frame_cnt),   64'd1);
        check_val("hg_err", 64'(sync_err),    64'd0);

        // Back-to-back good frame, then early sync.
        drive(1'b1, 1'b1, 8'h01);
        drive(1'b1, 1'b0, 8'h02);
        drive(1'b1, 1'b0, 8'h03);
        drive(1'b1, 1'b0, 8'h04);
        check_val("es_fd0",  64'(frame_data),  64'h04030201);
        check_val("es_fv0",  64'(frame_valid), 64'd1);
        check_val("es_cnt0", 64'(frame_cnt),   64'd2);
        drive(1'b1, 1'b1, 8'hAA);
        check_val("es_errAA", 64'(sync_err), 64'd0);
        drive(1'b1, 1'b0, 8'hBB);
        drive(1'b1, 1'b1, 8'hCC);
        check_val("es_errCC",  64'(sync_err),   64'd1);
        check_val("es_lockCC", 64'(locked),     64'd1);
        check_val("es_fdCC",   64'(frame_data), 64'h04030201);
        drive(1'b1, 1'b0, 8'hDD);
        check_val("es_errDD",  64'(sync_err),   64'd0);
        drive(1'b1, 1'b0, 8'hEE);
        check_val("es_fdEE",   64'(frame_data), 64'h04030201);
        drive(1'b1, 1'b0, 8'hFF);
        check_val("es_fd",  64'(frame_data),  64'hFFEEDDCC);
        check_val("es_fv",  64'(frame_valid), 64'd1);
        check_val("es_cnt", 64'(frame_cnt),   64'd3);
        check_val("es_err", 64'(sync_err),    64'd0);

        // Missing sync right after a completed frame.
        drive(1'b1, 1'b0, 8'h55);
        check_val("ms_err",  64'(sync_err),    64'd1);
        check_val("ms_lock", 64'(locked),      64'd0);
        check_val("ms_fv",   64'(frame_valid), 64'd0);
        check_val("ms_fd",   64'(frame_data),  64'hFFEEDDCC);
        idle(1);
        check_val("ms_err1", 64'(sync_err), 64'd0);
        drive(1'b1, 1'b1, 8'h61);
        check_val("ms_relock", 64'(locked), 64'd1);
        drive(1'b1, 1'b0, 8'h62);
        drive(1'b1, 1'b0, 8'h63);
        drive(1'b1, 1'b0, 8'h64);
        check_val("ms_fd2",  64'(frame_data),  64'h64636261);
        check_val("ms_fv2",  64'(frame_valid), 64'd1);
        check_val("ms_cnt2", 64'(frame_cnt),   64'd4);

        // Reset mid-frame.
        drive(1'b1, 1'b1, 8'h01);
        drive(1'b1, 1'b0, 8'h02);
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        check_val("rm_fd",   64'(frame_data), 64'd0);
        check_val("rm_lock", 64'(locked),     64'd0);
        check_val("rm_cnt",  64'(frame_cnt),  64'd0);
        drive(1'b1, 1'b0, 8'h03);
        check_val("rm_fv3",  64'(frame_valid), 64'd0);
        check_val("rm_err3", 64'(sync_err),    64'd0);
        drive(1'b1, 1'b0, 8'h04);
        check_val("rm_fv4",  64'(frame_valid), 64'd0);
        check_val("rm_lock4", 64'(locked),     64'd0);
        check_val("rm_fd4",  64'(frame_data),  64'd0);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
